pool_maxpool_axis: RTL and testbench

//  2x2/stride-2 signed int8 max-pool engine fed by the pool VDMA MM2S stream, results returned on the S2MM stream.

---
 rtl/pool_pkg.sv | 34 +++
 rtl/pool_line_buf.sv | 38 +++
 rtl/pool_maxpool_axis.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_pool_maxpool_axis.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// pool_pkg: shared definitions for the 2x2/stride-2 max-pool engine.
//   - APB register offsets (CTRL, STATUS, WIDTH, ROWS)
//   - STATUS / CTRL bit positions
//   - FSM state encoding (pool_state_t)
//   - smax8: signed int8 maximum, relu8: clamp negative int8 to zero
package pool_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_WIDTH  = 4'h8;
  localparam logic [3:0] ADDR_ROWS   = 4'hC;

  localparam int CTRL_START       = 0;
  localparam int STATUS_BUSY      = 0;
  localparam int STATUS_DONE      = 1;
  localparam int STATUS_TLAST_ERR = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVEN = 2'd1,
    ST_ODD  = 2'd2,
    ST_DONE = 2'd3
  } pool_state_t;

  // Signed int8 maximum: 0x80 (-128) is the lowest value.
  function automatic logic [7:0] smax8(input logic [7:0] a, input logic [7:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic [7:0] relu8(input logic [7:0] a);
    return a[7] ? 8'h00 : a;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf: simple dual-port line buffer holding the horizontally pooled
// even row, one 32-bit word (4 int8 values) per input word pair.
// Ports:
//   clk               clock
//   wr_en/wr_addr/wr_data   write port (EVEN row, second word of pair)
//   rd_en/rd_addr     read request (ODD row, first word of pair)
//   rd_data           registered read data; holds until the next rd_en
// Contents are not reset.
module pool_line_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read is issued on the first word of the pair, so the data is ready
  // by the time the second word arrives, however late that is.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/pool_maxpool_axis.sv
// pool_maxpool_axis: 2x2/stride-2 signed int8 max-pool engine.
// Input frames arrive on the S_AXIS stream (4 pixels per word, byte0 leftmost),
// rows of all channels back-to-back; pooled words leave on M_AXIS.
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   S_AXIS_*                input stream (TKEEP/TUSER ignored, TLAST checked only)
//   M_AXIS_*                output stream (TKEEP=F, TUSER first word, TLAST last word)
//   P*                      APB slave: 0x00 CTRL, 0x04 STATUS, 0x08 WIDTH, 0x0C ROWS
//   dbg_state               current FSM state
// Build option: POOL_RELU_EN clamps every output byte to max(x,0) in the
// output register stage (latency unchanged).
//
// Handshake: a word moves on a stream when TVALID and TREADY are both high at a
// rising CLK edge. The producer holds TVALID and data stable until that edge and
// never withdraws TVALID; TREADY may change freely and never depends on a
// combinational path from the same interface's TVALID.
module pool_maxpool_axis
  import pool_pkg::*;
#(
  parameter int MAX_WIDTH = 512,
  parameter int ROWS_W    = 12
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic [3:0]  S_AXIS_TKEEP,
  input  logic        S_AXIS_TUSER,
  input  logic        S_AXIS_TLAST,
  input  logic        S_AXIS_TVALID,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic [3:0]  M_AXIS_TKEEP,
  output logic        M_AXIS_TUSER,
  output logic        M_AXIS_TLAST,
  output logic        M_AXIS_TVALID,
  input  logic        M_AXIS_TREADY,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output pool_state_t dbg_state
);

  localparam int PAIRS = MAX_WIDTH / 8;
  localparam int COL_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  pool_state_t       state_q, state_d;
  logic [15:0]       width_q;
  logic [ROWS_W-1:0] rows_q;
  logic              done_q, tlast_err_q;
  logic [COL_W-1:0]  col_q;
  logic [ROWS_W-1:0] row_q;
  logic              word_sel_q;   // 0: first word of pair, 1: second
  logic [15:0]       h_lo_q;       // horizontal maxima of the first word
  logic              first_out_q;  // next output word is the first of the frame
  logic [31:0]       m_tdata_q;
  logic              m_tvalid_q, m_tuser_q, m_tlast_q;
  logic [31:0]       prdata_q;
  logic              pslverr_q;

  logic              busy;
  logic              accept, pair_end, col_wrap, last_row, is_final;
  logic              out_load, lb_wr, lb_rd;
  logic [15:0]       pairs_m1;
  logic [ROWS_W-1:0] rows_m1;
  logic [15:0]       word_h;
  logic [31:0]       pair_h, lb_rd_data, pooled, out_word;

  // ---------------------------------------------------------------------------
  // APB
  // ---------------------------------------------------------------------------
  logic        apb_setup, apb_access, addr_ok, apb_err, reg_wr, start;
  logic [3:0]  apb_off;
  logic [31:0] rd_mux;

  assign apb_setup  = PSEL && !PENABLE;
  assign apb_access = PSEL && PENABLE;
  assign addr_ok    = (PADDR[31:4] == 28'd0) && (PADDR[1:0] == 2'd0);
  assign apb_off    = PADDR[3:0];
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    apb_err = 1'b0;
    rd_mux  = '0;
    if (!addr_ok) begin
      apb_err = 1'b1;
    end else begin
      case (apb_off)
        ADDR_CTRL: rd_mux = '0;
        ADDR_STATUS: begin
          rd_mux[STATUS_BUSY]      = busy;
          rd_mux[STATUS_DONE]      = done_q;
          rd_mux[STATUS_TLAST_ERR] = tlast_err_q;
          if (PWRITE) apb_err = 1'b1;
        end
        ADDR_WIDTH: begin
          rd_mux[15:0] = width_q;
          if (PWRITE && busy) apb_err = 1'b1;
        end
        ADDR_ROWS: begin
          rd_mux[ROWS_W-1:0] = rows_q;
          if (PWRITE && busy) apb_err = 1'b1;
        end
        default: apb_err = 1'b1;
      endcase
    end
  end

  // Response is decided in the setup phase and presented in the access phase;
  // the write itself lands at the end of the access phase unless it was refused.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else if (apb_setup) begin
      prdata_q  <= PWRITE ? 32'd0 : rd_mux;
      pslverr_q <= apb_err;
    end else begin
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end
  end

  assign reg_wr = apb_access && PWRITE && !pslverr_q;
  assign start  = reg_wr && (apb_off == ADDR_CTRL) && PWDATA[CTRL_START] && (state_q == ST_IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      width_q <= 16'd8;
      rows_q  <= ROWS_W'(2);
    end else if (reg_wr) begin
      if (apb_off == ADDR_WIDTH) width_q <= PWDATA[15:0];
      if (apb_off == ADDR_ROWS)  rows_q  <= PWDATA[ROWS_W-1:0];
    end
  end

  assign PRDATA  = prdata_q;
  assign PSLVERR = pslverr_q;
  assign PREADY  = 1'b1;

  // ---------------------------------------------------------------------------
  // Frame position
  // ---------------------------------------------------------------------------
  assign pairs_m1 = {3'b000, width_q[15:3]} - 16'd1;
  assign rows_m1  = rows_q - 1'b1;
  assign col_wrap = ({{(16-COL_W){1'b0}}, col_q} == pairs_m1);
  assign last_row = (row_q == rows_m1);

  always_comb begin
    S_AXIS_TREADY = 1'b0;
    case (state_q)
      ST_EVEN: S_AXIS_TREADY = 1'b1;
      ST_ODD:  S_AXIS_TREADY = !m_tvalid_q || M_AXIS_TREADY;
      default: S_AXIS_TREADY = 1'b0;
    endcase
  end

  assign accept   = S_AXIS_TVALID && S_AXIS_TREADY;
  assign pair_end = accept && word_sel_q;
  assign is_final = (state_q == ST_ODD) && word_sel_q && col_wrap && last_row;
  assign out_load = pair_end && (state_q == ST_ODD);
  assign lb_wr    = pair_end && (state_q == ST_EVEN);
  assign lb_rd    = accept && !word_sel_q && (state_q == ST_ODD);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EVEN;
      ST_EVEN: if (pair_end && col_wrap) state_d = ST_ODD;
      ST_ODD:  if (pair_end && col_wrap) state_d = last_row ? ST_DONE : ST_EVEN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign dbg_state = state_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      col_q      <= '0;
      row_q      <= '0;
      word_sel_q <= 1'b0;
      h_lo_q     <= '0;
    end else if (start) begin
      col_q      <= '0;
      row_q      <= '0;
      word_sel_q <= 1'b0;
    end else if (accept) begin
      word_sel_q <= !word_sel_q;
      if (!word_sel_q) begin
        h_lo_q <= word_h;
      end else if (col_wrap) begin
        col_q <= '0;
        row_q <= row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      done_q      <= 1'b0;
      tlast_err_q <= 1'b0;
    end else if (start) begin
      done_q      <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      if (state_q == ST_DONE) done_q <= 1'b1;
      // TLAST is only monitored: a misplaced or missing one is flagged and
      // the frame geometry from WIDTH/ROWS keeps driving the datapath.
      if (accept && (S_AXIS_TLAST != is_final)) tlast_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // Each input word gives two horizontal maxima: (p0,p1) -> low byte, (p2,p3) -> high byte.
  assign word_h = {smax8(S_AXIS_TDATA[31:24], S_AXIS_TDATA[23:16]),
                   smax8(S_AXIS_TDATA[15:8],  S_AXIS_TDATA[7:0])};
  assign pair_h = {word_h, h_lo_q};

  pool_line_buf #(
    .DEPTH (PAIRS),
    .AW    (COL_W)
  ) u_line_buf (
    .clk     (CLK),
    .wr_en   (lb_wr),
    .wr_addr (col_q),
    .wr_data (pair_h),
    .rd_en   (lb_rd),
    .rd_addr (col_q),
    .rd_data (lb_rd_data)
  );

  always_comb begin
    pooled   = '0;
    out_word = '0;
    for (int k = 0; k < 4; k++) begin
      pooled[8*k +: 8] = smax8(pair_h[8*k +: 8], lb_rd_data[8*k +: 8]);
`ifdef POOL_RELU_EN
      out_word[8*k +: 8] = relu8(pooled[8*k +: 8]);
`else
      out_word[8*k +: 8] = pooled[8*k +: 8];
`endif
    end
  end

  // Single output register. ODD-row S_AXIS_TREADY already guarantees the slot
  // is free (or being emptied this cycle) whenever out_load fires.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tuser_q   <= 1'b0;
      m_tlast_q   <= 1'b0;
      first_out_q <= 1'b0;
    end else begin
      if (start) first_out_q <= 1'b1;
      if (m_tvalid_q && M_AXIS_TREADY) m_tvalid_q <= 1'b0;
      if (out_load) begin
        m_tvalid_q  <= 1'b1;
        m_tdata_q   <= out_word;
        m_tuser_q   <= first_out_q;
        m_tlast_q   <= last_row && col_wrap;
        first_out_q <= 1'b0;
      end
    end
  end

  assign M_AXIS_TDATA  = m_tdata_q;
  assign M_AXIS_TKEEP  = 4'hF;
  assign M_AXIS_TUSER  = m_tuser_q;
  assign M_AXIS_TLAST  = m_tlast_q;
  assign M_AXIS_TVALID = m_tvalid_q;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXIS_TKEEP, S_AXIS_TUSER, PWDATA};

endmodule

// File: tb/tb_pool_maxpool_axis.sv
// tb_pool_maxpool_axis: directed bench for pool_maxpool_axis.
// Frames are held as pixel images; the expected output words are computed from
// the images by plain 2x2 signed maxima and queued; one compare process checks
// every output handshake against the queue and that stalled outputs hold.
module tb_pool_maxpool_axis;
  import pool_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] S_AXIS_TDATA = '0;
  logic [3:0]  S_AXIS_TKEEP = 4'hF;
  logic        S_AXIS_TUSER = 1'b0;
  logic        S_AXIS_TLAST = 1'b0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic [31:0] PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  pool_state_t dbg_state;

  always #5 CLK = ~CLK;

  pool_maxpool_axis dut (
    .CLK(CLK), .RESET(RESET),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];           // {tuser, tlast, tdata}
  logic [7:0]  img [0:7][0:63];
  int          rdy_mode = 0;       // 0 always ready, 1 ~30% stall, 2 never ready
  int          out_cnt = 0;
  logic [33:0] last_word = '0;
  logic [33:0] held = '0;
  logic        stall_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Downstream ready generator
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       M_AXIS_TREADY = 1'b1;
        1:       M_AXIS_TREADY = ($urandom_range(0, 9) >= 3);
        default: M_AXIS_TREADY = 1'b0;
      endcase
    end
  end

  // Compare process: every output handshake, plus hold while stalled
  always @(negedge CLK) begin
    logic [33:0] cur;
    logic [33:0] e;
    cur = {M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA};
    if (RESET) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!M_AXIS_TVALID || cur !== held) begin
          errors++;
          $display("FAIL out_hold actual=%0b/%0h required=1/%0h", M_AXIS_TVALID, cur, held);
        end
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        checks++;
        out_cnt++;
        last_word = cur;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected actual=%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL out_word actual=%0h required=%0h", cur, e);
          end
        end
      end
      stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
      held = cur;
    end
  end

  // ---------------------------------------------------------------------------
  // Model: expected output words of a frame held in img
  // ---------------------------------------------------------------------------
  task automatic model_frame(input int w, input int rows);
    int npairs, nrp, j, m, v;
    logic [31:0] d;
    logic u, l;
    npairs = w / 8;
    nrp = rows / 2;
    for (int rp = 0; rp < nrp; rp++) begin
      for (int wd = 0; wd < npairs; wd++) begin
        d = '0;
        for (int k = 0; k < 4; k++) begin
          j = wd * 4 + k;
          m = -128;
          for (int dr = 0; dr < 2; dr++) begin
            for (int dc = 0; dc < 2; dc++) begin
              v = int'($signed(img[2*rp+dr][2*j+dc]));
              if (v > m) m = v;
            end
          end
`ifdef POOL_RELU_EN
          if (m < 0) m = 0;
`endif
          d[8*k +: 8] = 8'(m);
        end
        u = (rp == 0 && wd == 0);
        l = (rp == nrp - 1 && wd == npairs - 1);
        exp_q.push_back({u, l, d});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    @(posedge CLK); #1;
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    @(negedge CLK);
    err = PSLVERR;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(posedge CLK); #1;
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    @(negedge CLK);
    d = PRDATA;
    err = PSLVERR;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic start_frame(input int w, input int rows);
    logic e;
    apb_write(32'h8, 32'(w), e);
    apb_write(32'hC, 32'(rows), e);
    apb_write(32'h0, 32'h1, e);
  endtask

  // Leaves TVALID high so consecutive words go back-to-back.
  task automatic send_word(input logic [31:0] d, input logic lst);
    int t;
    S_AXIS_TDATA = d; S_AXIS_TLAST = lst; S_AXIS_TVALID = 1'b1;
    t = 0;
    forever begin
      @(negedge CLK);
      if (S_AXIS_TREADY) break;
      t++;
      if (t > 3000) begin
        checks++; errors++;
        $display("FAIL s_ready_timeout actual=0 required=1");
        break;
      end
    end
    @(posedge CLK); #1;
  endtask

  // Streams rows [0, nrows) of img; bad_last < 0 puts TLAST on the final word.
  task automatic send_rows(input int w, input int rows, input int nrows, input int extra, input int bad_last);
    int total, idx;
    logic [31:0] word;
    total = rows * w / 4;
    idx = 0;
    for (int r = 0; r < nrows; r++) begin
      for (int wd = 0; wd < w / 4; wd++) begin
        word = {img[r][4*wd+3], img[r][4*wd+2], img[r][4*wd+1], img[r][4*wd]};
        send_word(word, (bad_last < 0) ? (idx == total - 1) : (idx == bad_last));
        idx++;
      end
    end
    for (int wd = 0; wd < extra; wd++) begin
      word = {img[nrows][4*wd+3], img[nrows][4*wd+2], img[nrows][4*wd+1], img[nrows][4*wd]};
      send_word(word, 1'b0);
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] st;
    logic e;
    int t;
    t = 0;
    forever begin
      apb_read(32'h4, st, e);
      if (!st[STATUS_BUSY] && exp_q.size() == 0) break;
      t++;
      if (t > 500) begin
        checks++; errors++;
        $display("FAIL %s_timeout actual=busy required=idle", tag);
        break;
      end
    end
  endtask

  task automatic fill_random(input int rows, input int w);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < w; c++)
        img[r][c] = 8'($urandom_range(0, 255));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    logic        e;
    int          base;

    repeat (4) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);

    // Reset state
    chk("rst_s_tready", 64'(S_AXIS_TREADY), 64'd0);
    chk("rst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    chk("rst_m_tdata",  64'(M_AXIS_TDATA),  64'd0);
    chk("rst_m_tuser_tlast", 64'({M_AXIS_TUSER, M_AXIS_TLAST}), 64'd0);
    chk("rst_prdata",   64'(PRDATA), 64'd0);
    chk("rst_pslverr",  64'(PSLVERR), 64'd0);
    chk("rst_m_tkeep",  64'(M_AXIS_TKEEP), 64'hF);
    chk("rst_pready",   64'(PREADY), 64'd1);
    chk("rst_state",    64'(dbg_state), 64'(ST_IDLE));
    apb_read(32'h4, rd, e); chk("rst_status", 64'(rd), 64'd0);
    apb_read(32'h8, rd, e); chk("rst_width",  64'(rd), 64'd8);
    apb_read(32'hC, rd, e); chk("rst_rows",   64'(rd), 64'd2);

    // Sequential pixels, WIDTH=8, ROWS=2 -> single word 0x100E0C0A
    rdy_mode = 0;
    for (int c = 0; c < 8; c++) begin
      img[0][c] = 8'(c + 1);
      img[1][c] = 8'(c + 9);
    end
    model_frame(8, 2);
    base = out_cnt;
    start_frame(8, 2);
    send_rows(8, 2, 2, 0, -1);
    wait_idle("seq");
    chk("seq_count", 64'(out_cnt - base), 64'd1);
    chk("seq_word", 64'(last_word), {30'd0, 1'b1, 1'b1, 32'h100E0C0A});
    apb_read(32'h4, rd, e); chk("seq_status", 64'(rd), 64'h2);

    // Signed compare: -128 rows against -1/-128 rows
    for (int c = 0; c < 8; c++) begin
      img[0][c] = 8'h80;
      img[1][c] = (c % 2 == 0) ? 8'hFF : 8'h80;
    end
    model_frame(8, 2);
    start_frame(8, 2);
    send_rows(8, 2, 2, 0, -1);
    wait_idle("signed");
`ifdef POOL_RELU_EN
    chk("signed_word", 64'(last_word[31:0]), 64'h00000000);
`else
    chk("signed_word", 64'(last_word[31:0]), 64'hFFFFFFFF);
`endif

    // WIDTH=32, ROWS=4, random data, downstream stalls; busy-time register access
    rdy_mode = 1;
    fill_random(4, 32);
    model_frame(32, 4);
    base = out_cnt;
    start_frame(32, 4);
    apb_write(32'h8, 32'd8, e);  chk("busy_width_err", 64'(e), 64'd1);
    apb_write(32'hC, 32'd2, e);  chk("busy_rows_err",  64'(e), 64'd1);
    apb_write(32'h0, 32'h1, e);  chk("busy_start_err", 64'(e), 64'd0);
    apb_read(32'h4, rd, e);      chk("busy_status",    64'(rd), 64'h1);
    send_rows(32, 4, 4, 0, -1);
    wait_idle("rand");
    chk("rand_count", 64'(out_cnt - base), 64'd8);
    apb_read(32'h8, rd, e); chk("rand_width_kept", 64'(rd), 64'd32);
    apb_read(32'hC, rd, e); chk("rand_rows_kept",  64'(rd), 64'd4);

    // Address decode errors
    rdy_mode = 0;
    apb_read(32'h10, rd, e);      chk("unmapped_err",  64'(e), 64'd1);
    apb_read(32'h2, rd, e);       chk("unaligned_err", 64'(e), 64'd1);
    apb_write(32'h4, 32'h7, e);   chk("status_wr_err", 64'(e), 64'd1);
    apb_read(32'h4, rd, e);       chk("status_rd_ok",  64'(e), 64'd0);
    chk("status_unchanged", 64'(rd), 64'h2);

    // TLAST on word 3 of 4 instead of the final word
    fill_random(2, 8);
    model_frame(8, 2);
    base = out_cnt;
    start_frame(8, 2);
    send_rows(8, 2, 2, 0, 2);
    wait_idle("tlast");
    chk("tlast_count", 64'(out_cnt - base), 64'd1);
    apb_read(32'h4, rd, e); chk("tlast_status", 64'(rd), 64'h6);

    // Reset in the middle of the odd row with an output pending
    rdy_mode = 2;
    fill_random(2, 16);
    model_frame(16, 2);
    start_frame(16, 2);
    send_rows(16, 2, 1, 2, -1);
    @(negedge CLK);
    @(negedge CLK);
    chk("midrst_pending_valid", 64'(M_AXIS_TVALID), 64'd1);
    chk("midrst_pending_word", 64'({M_AXIS_TUSER, M_AXIS_TLAST, M_AXIS_TDATA}), 64'(exp_q[0]));
    @(posedge CLK); #1 RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_m_tvalid", 64'(M_AXIS_TVALID), 64'd0);
    exp_q.delete();
    @(posedge CLK); #1 RESET = 1'b0;
    rdy_mode = 0;
    apb_read(32'h4, rd, e); chk("midrst_status", 64'(rd), 64'd0);
    apb_read(32'h8, rd, e); chk("midrst_width",  64'(rd), 64'd8);

    // Restarted frame after the abort
    fill_random(2, 16);
    model_frame(16, 2);
    base = out_cnt;
    start_frame(16, 2);
    send_rows(16, 2, 2, 0, -1);
    wait_idle("restart");
    chk("restart_count", 64'(out_cnt - base), 64'd2);
    apb_read(32'h4, rd, e); chk("restart_status", 64'(rd), 64'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
